// File: rtl/cordic_iter_ctrl_pkg.sv
// cordic_iter_ctrl_pkg: sequencer state type built on the shared encodings.
package cordic_iter_ctrl_pkg;
  `include "cordic_ctrl_defs.vh"
  typedef enum logic [ST_W-1:0] {
    IDLE     = ST_IDLE,
    LOAD     = ST_LOAD,
    REDUCE   = ST_REDUCE,
    ITER     = ST_ITER,
    FIX      = ST_FIX,
    RESULT   = ST_RESULT,
    WAIT_ACK = ST_WAIT_ACK
  } state_t;
endpackage

// File: rtl/cordic_ctrl_defs.vh
// cordic_ctrl_defs: state encodings and state width shared by the CORDIC sequencer.
`ifndef CORDIC_CTRL_DEFS_VH
`define CORDIC_CTRL_DEFS_VH
localparam int ST_W = 3;
localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
localparam logic [ST_W-1:0] ST_LOAD     = 3'd1;
localparam logic [ST_W-1:0] ST_REDUCE   = 3'd2;
localparam logic [ST_W-1:0] ST_ITER     = 3'd3;
localparam logic [ST_W-1:0] ST_FIX      = 3'd4;
localparam logic [ST_W-1:0] ST_RESULT   = 3'd5;
localparam logic [ST_W-1:0] ST_WAIT_ACK = 3'd6;
`endif

// File: rtl/cordic_iter_cnt.sv
// cordic_iter_cnt: saturating iteration counter with sync clear and terminal compare at N_ITER-1.
module cordic_iter_cnt #(
  parameter int ITER_W = 4,
  parameter int N_ITER = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ITER_W-1:0] cnt_o,
  output logic              term_o
);
  localparam logic [ITER_W-1:0] LAST = ITER_W'(N_ITER - 1);
  logic [ITER_W-1:0] cnt_q, cnt_d;
  assign term_o = cnt_q == LAST;
  assign cnt_o  = cnt_q;
  always_comb cnt_d = clr_i ? '0 : (en_i && !term_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: CORDIC sequencing FSM; CORDIC_QUAD_REDUCE_EN adds REDUCE/FIX states and their enables.
module cordic_iter_ctrl
  import cordic_iter_ctrl_pkg::*;
#(
  parameter int ITER_W = 4,
  parameter int N_ITER = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ack,
  output logic              ready_out,
  output logic              busy,
  output logic              load_init,
  output logic              sel_init,
  output logic              enab_iter,
  output logic [ITER_W-1:0] iter_idx,
  output logic              last_iter,
  output logic              enab_result,
  output logic              done
`ifdef CORDIC_QUAD_REDUCE_EN
  ,
  output logic              enab_reduce,
  output logic              enab_fix
`endif
);
  if (N_ITER < 1 || N_ITER > 2 ** ITER_W) begin : g_bad_n_iter
    $error("N_ITER must lie in 1..2**ITER_W");
  end
`ifdef CORDIC_QUAD_REDUCE_EN
  localparam state_t AFTER_LOAD = REDUCE;
  localparam state_t AFTER_ITER = FIX;
`else
  localparam state_t AFTER_LOAD = ITER;
  localparam state_t AFTER_ITER = RESULT;
`endif
  state_t state_q, state_d;
  logic   term;
  cordic_iter_cnt #(.ITER_W(ITER_W), .N_ITER(N_ITER)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (load_init),
    .en_i  (enab_iter),
    .cnt_o (iter_idx),
    .term_o(term)
  );
  assign last_iter = enab_iter & term;
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d     = state_q;
    ready_out   = 1'b0;
    busy        = 1'b1;
    load_init   = 1'b0;
    sel_init    = 1'b0;
    enab_iter   = 1'b0;
    enab_result = 1'b0;
    done        = 1'b0;
`ifdef CORDIC_QUAD_REDUCE_EN
    enab_reduce = 1'b0;
    enab_fix    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        busy      = 1'b0;
        state_d   = start ? LOAD : IDLE;
      end
      LOAD: begin
        load_init = 1'b1;
        sel_init  = 1'b1;
        state_d   = AFTER_LOAD;
      end
`ifdef CORDIC_QUAD_REDUCE_EN
      REDUCE: begin
        enab_reduce = 1'b1;
        state_d     = ITER;
      end
      FIX: begin
        enab_fix = 1'b1;
        state_d  = RESULT;
      end
`endif
      ITER: begin
        enab_iter = 1'b1;
        state_d   = term ? AFTER_ITER : ITER;
      end
      RESULT: begin
        enab_result = 1'b1;
        state_d     = WAIT_ACK;
      end
      WAIT_ACK: begin
        done    = 1'b1;
        state_d = ack ? IDLE : WAIT_ACK;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: scoreboard bench over N_ITER = 14, 1 and 16 sharing one random stimulus stream.
module tb_cordic_iter_ctrl;
  localparam int NI = 3;
`ifdef CORDIC_QUAD_REDUCE_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif
  localparam int LAST_EDGE = 3060;

  function automatic int nv(input int i);
    return i == 0 ? 14 : i == 1 ? 1 : 16;
  endfunction

  // mask bits: 0 load, 1 iter, 2 result, 3 reduce, 4 fix, 5 done rising
  typedef struct {
    int         inst;
    int         cyc;
    logic [5:0] mask;
    logic       sel;
    logic       last;
    logic [3:0] idx;
  } item_t;

  item_t q[$];
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, ack = 1'b0;
  int   ecnt = 0;
  int   vectors = 0, miscompares = 0;
  bit   busy_m [NI];
  bit   idx0_m [NI];
  int   acc_k  [NI];
  logic [NI-1:0] prev_done = '0;

  logic [NI-1:0] ready_w, busy_w, load_w, sel_w, iter_w, last_w, result_w, done_w;
  logic [NI-1:0] reduce_w, fix_w;
  logic [3:0]    idx_w [NI];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cordic_iter_ctrl #(.ITER_W(4), .N_ITER(nv(g))) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ack        (ack),
      .ready_out  (ready_w[g]),
      .busy       (busy_w[g]),
      .load_init  (load_w[g]),
      .sel_init   (sel_w[g]),
      .enab_iter  (iter_w[g]),
      .iter_idx   (idx_w[g]),
      .last_iter  (last_w[g]),
      .enab_result(result_w[g]),
      .done       (done_w[g])
`ifdef CORDIC_QUAD_REDUCE_EN
      ,
      .enab_reduce(reduce_w[g]),
      .enab_fix   (fix_w[g])
`endif
    );
`ifndef CORDIC_QUAD_REDUCE_EN
    assign reduce_w[g] = 1'b0;
    assign fix_w[g]    = 1'b0;
`endif
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d", nm, i, ecnt, act, exp);
    end
  endtask

  function automatic void push(input int i, input int c, input logic [5:0] m,
                               input logic s, input logic l, input int x);
    item_t t;
    t.inst = i; t.cyc = c; t.mask = m; t.sel = s; t.last = l; t.idx = 4'(x);
    q.push_back(t);
  endfunction

  function automatic int first_of(input int i);
    for (int j = 0; j < q.size(); j++) if (q[j].inst == i) return j;
    return -1;
  endfunction

  // Expected behaviour for edge e: time arithmetic from the accept edge of each operation.
  task automatic model_edge(input int e);
    if (!rst) q.delete();
    for (int i = 0; i < NI; i++) begin
      int n, k;
      n = nv(i);
      if (!rst) begin
        busy_m[i] = 0;
        idx0_m[i] = 1;
      end else if (!busy_m[i]) begin
        if (start) begin
          busy_m[i] = 1;
          idx0_m[i] = 0;
          acc_k[i]  = e;
          k = e;
          push(i, k, 6'd1, 1'b1, 1'b0, 0);
          if (PRE == 1) push(i, k + 1, 6'd8, 1'b0, 1'b0, 0);
          for (int j = 0; j < n; j++) push(i, k + 1 + PRE + j, 6'd2, 1'b0, j == n - 1, j);
          if (PRE == 1) push(i, k + 1 + PRE + n, 6'd16, 1'b0, 1'b0, 0);
          push(i, k + n + 1 + 2 * PRE, 6'd4, 1'b0, 1'b0, 0);
          push(i, k + n + 2 + 2 * PRE, 6'd32, 1'b0, 1'b0, 0);
        end
      end else if (ack && e - 1 >= acc_k[i] + n + 2 + 2 * PRE) begin
        busy_m[i] = 0;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    int p, c, dfrom;
    logic [5:0] obs;
    c = ecnt;
    for (int i = 0; i < NI; i++) begin
      obs = {done_w[i] & ~prev_done[i], fix_w[i], reduce_w[i], result_w[i], iter_w[i], load_w[i]};
      p = first_of(i);
      while (p >= 0 && q[p].cyc < c) begin
        chk("missing_event", i, 0, int'(q[p].mask));
        q.delete(p);
        p = first_of(i);
      end
      if (p >= 0 && q[p].cyc == c) begin
        chk("event_mask", i, int'(obs), int'(q[p].mask));
        chk("sel_init", i, int'(sel_w[i]), int'(q[p].sel));
        chk("last_iter", i, int'(last_w[i]), int'(q[p].last));
        if (q[p].mask == 6'd2) chk("iter_idx", i, int'(idx_w[i]), int'(q[p].idx));
        q.delete(p);
      end else if (obs != 0 || sel_w[i] || last_w[i]) begin
        chk("unexpected_event", i, int'({obs, sel_w[i], last_w[i]}), 0);
      end
      dfrom = acc_k[i] + nv(i) + 2 + 2 * PRE;
      chk("ready_out", i, int'(ready_w[i]), int'(!busy_m[i]));
      chk("busy", i, int'(busy_w[i]), int'(busy_m[i]));
      chk("done", i, int'(done_w[i]), int'(busy_m[i] && c >= dfrom));
      if (idx0_m[i]) chk("reset_iter_idx", i, int'(idx_w[i]), 0);
      prev_done[i] = done_w[i];
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      busy_m[i] = 0;
      idx0_m[i] = 1;
      acc_k[i]  = 0;
    end
    forever begin
      int e;
      bit rnd;
      @(negedge clk);
      #1;
      e   = ecnt + 1;
      rnd = e >= 200 && e < 3000;
      rst   = !(e <= 3 || e == 77 || (rnd && $urandom_range(99) == 0));
      start = e == 5 || e == 70 || e == 80 || (e >= 120 && e < 200) ||
              (rnd && $urandom_range(99) < 30);
      ack   = e == 10 || e == 12 || (e >= 60 && e <= 62) || e == 110 ||
              (e >= 120 && e < 200) || (rnd && $urandom_range(99) < 30) || e >= 3000;
      if (e >= 3000) start = 1'b0;
      model_edge(e);
      if (e == LAST_EDGE) begin
        @(negedge clk);
        #2;
        chk("pending_events", -1, q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end
endmodule
